// File: rtl/si_alu_pkg.sv
// Opcode constants and legality decode shared by si_alu_pipe and its bench.
// Opcodes 9 and 10 are legal only when SI_ALU_PIPE_EXT_OPS_EN is defined.
package si_alu_pkg;

    localparam logic [3:0] OP_XOR_ROTL = 4'd5;
    localparam logic [3:0] OP_ROTR_XOR = 4'd6;
    localparam logic [3:0] OP_ROTL_ADD = 4'd7;
    localparam logic [3:0] OP_SUB_ROTR = 4'd8;
    localparam logic [3:0] OP_ADD_ROTL = 4'd9;
    localparam logic [3:0] OP_ROTR_SUB = 4'd10;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_XOR_ROTL, OP_ROTR_XOR, OP_ROTL_ADD, OP_SUB_ROTR: legal = 1'b1;
`ifdef SI_ALU_PIPE_EXT_OPS_EN
            OP_ADD_ROTL, OP_ROTR_SUB: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/si_rot.sv
// Combinational rotator: each output bit gathers from (bit -/+ amount) mod WIDTH.
// WIDTH must be a power of two so the index wraps by plain truncation.
module si_rot #(
    parameter int WIDTH = 32,
    parameter int ROT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [ROT_W-1:0] i_amt,
    input  logic             i_left,
    output logic [WIDTH-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [ROT_W-1:0] w_src;
            assign w_src       = i_left ? (ROT_W'(gi) - i_amt) : (ROT_W'(gi) + i_amt);
            assign o_data[gi]  = i_data[w_src];
        end
    endgenerate

endmodule

// File: rtl/si_alu_pipe.sv
// Two-stage rotate/arith ALU with valid/ready flow control on both sides.
// Define SI_ALU_PIPE_EXT_OPS_EN to enable opcodes 9 (rotl of sum) and 10 (rotr minus RT).
module si_alu_pipe
    import si_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    input  logic [ROT_W-1:0] ROT_AM,
    input  logic [3:0]       ALU_CNTRL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] VAL,
    output logic             ILLEGAL
);

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] r_s1_rt;
    logic [ROT_W-1:0] r_s1_amt;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_val;
    logic             r_illegal;

    logic             w_s2_adv;
    logic [WIDTH-1:0] w_rot1;
    logic [WIDTH-1:0] w_rot2;
    logic [WIDTH-1:0] w_s1_data;
    logic [WIDTH-1:0] w_s2_data;

    // Stage 1 moves whenever stage 2 is empty or its result leaves this cycle.
    assign w_s2_adv  = !r_s2_valid || OUT_READY;
    assign IN_READY  = !r_s1_valid || w_s2_adv;
    assign OUT_VALID = r_s2_valid;
    assign VAL       = r_val;
    assign ILLEGAL   = r_illegal;

    si_rot #(.WIDTH(WIDTH), .ROT_W(ROT_W)) u_rot1 (
        .i_data (RS),
        .i_amt  (ROT_AM),
        .i_left (ALU_CNTRL == OP_ROTL_ADD),
        .o_data (w_rot1)
    );

    si_rot #(.WIDTH(WIDTH), .ROT_W(ROT_W)) u_rot2 (
        .i_data (r_s1_data),
        .i_amt  (r_s1_amt),
        .i_left (r_s1_op != OP_SUB_ROTR),
        .o_data (w_rot2)
    );

    always_comb begin
        w_s1_data = '0;
        case (ALU_CNTRL)
            OP_XOR_ROTL:              w_s1_data = RS ^ RT;
            OP_ROTR_XOR, OP_ROTL_ADD: w_s1_data = w_rot1;
            OP_SUB_ROTR:              w_s1_data = RS - RT;
`ifdef SI_ALU_PIPE_EXT_OPS_EN
            OP_ADD_ROTL:              w_s1_data = RS + RT;
            OP_ROTR_SUB:              w_s1_data = w_rot1;
`endif
            default:                  w_s1_data = '0;
        endcase
    end

    // Unsupported opcodes fall through to zero so VAL is 0 whenever ILLEGAL is set.
    always_comb begin
        w_s2_data = '0;
        case (r_s1_op)
            OP_XOR_ROTL, OP_SUB_ROTR: w_s2_data = w_rot2;
            OP_ROTR_XOR:              w_s2_data = r_s1_data ^ r_s1_rt;
            OP_ROTL_ADD:              w_s2_data = r_s1_data + r_s1_rt;
`ifdef SI_ALU_PIPE_EXT_OPS_EN
            OP_ADD_ROTL:              w_s2_data = w_rot2;
            OP_ROTR_SUB:              w_s2_data = r_s1_data - r_s1_rt;
`endif
            default:                  w_s2_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_data  <= '0;
            r_s1_rt    <= '0;
            r_s1_amt   <= '0;
        end else if (IN_READY) begin
            r_s1_valid <= IN_VALID;
            if (IN_VALID) begin
                r_s1_op   <= ALU_CNTRL;
                r_s1_data <= w_s1_data;
                r_s1_rt   <= RT;
                r_s1_amt  <= ROT_AM;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_valid <= 1'b0;
            r_val      <= '0;
            r_illegal  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_val     <= w_s2_data;
                r_illegal <= !op_is_legal(r_s1_op);
            end
        end
    end

endmodule

// File: tb/tb_si_alu_pipe.sv
// Self-checking bench for si_alu_pipe: vector table, stall burst, random burst, mid-flight reset.
`timescale 1ns/1ps
module tb_si_alu_pipe;
    import si_alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int ROT_W = 5;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] RS = '0;
    logic [WIDTH-1:0] RT = '0;
    logic [ROT_W-1:0] ROT_AM = '0;
    logic [3:0]       ALU_CNTRL = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b1;
    logic [WIDTH-1:0] VAL;
    logic             ILLEGAL;

    si_alu_pipe #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RS(RS), .RT(RT), .ROT_AM(ROT_AM), .ALU_CNTRL(ALU_CNTRL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .VAL(VAL), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int next_id  = 0;
    bit watch_ready = 0;
    bit saw_low     = 0;

    typedef struct {
        logic [31:0] val;
        logic        ill;
        int          cyc;
        bit          chk_lat;
        int          id;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  amt;
        logic [31:0] exp_val;
        logic        exp_ill;
    } vec_t;
    vec_t vecs[14];

    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rotl_m(input logic [31:0] d, input int a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i + a) % 32] = d[i];
        return r;
    endfunction

    function automatic logic [31:0] rotr_m(input logic [31:0] d, input int a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = d[(i + a) % 32];
        return r;
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] amt, output logic [31:0] v, output logic ill);
        ill = 1'b0;
        case (op)
            4'd5:    v = rotl_m(rs ^ rt, int'(amt));
            4'd6:    v = rotr_m(rs, int'(amt)) ^ rt;
            4'd7:    v = rotl_m(rs, int'(amt)) + rt;
            4'd8:    v = rotr_m(rs - rt, int'(amt));
`ifdef SI_ALU_PIPE_EXT_OPS_EN
            4'd9:    v = rotl_m(rs + rt, int'(amt));
            4'd10:   v = rotr_m(rs, int'(amt)) - rt;
`endif
            default: begin v = '0; ill = 1'b1; end
        endcase
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    logic [31:0] held_val;
    logic        held_ill;
    bit          held = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            held = 0;
        end else begin
            if (held) begin
                check("stall_out_valid", OUT_VALID, 1'b1);
                check("stall_val", VAL, held_val);
                check("stall_illegal", ILLEGAL, held_ill);
            end
            held     = OUT_VALID && !OUT_READY;
            held_val = VAL;
            held_ill = ILLEGAL;
            if (OUT_VALID && OUT_READY) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got val=%08h ill=%0b with nothing outstanding", VAL, ILLEGAL);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    n_out++;
                    $display("OUT id=%0d val=%08h ill=%0b exp=%08h/%0b cycle=%0d", e.id, VAL, ILLEGAL, e.val, e.ill, cyc);
                    check("result_val", VAL, e.val);
                    check("result_illegal", ILLEGAL, e.ill);
                    if (e.chk_lat) check("latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] amt, input logic [31:0] ev, input logic ei, input bit lat);
        int  waited;
        bit  done;
        sb_t e;
        waited    = 0;
        done      = 0;
        IN_VALID  = 1'b1;
        ALU_CNTRL = op;
        RS        = rs;
        RT        = rt;
        ROT_AM    = amt;
        while (!done) begin
            @(negedge CLK);
            if (IN_READY) begin
                e.val = ev; e.ill = ei; e.cyc = cyc; e.chk_lat = lat; e.id = next_id;
                next_id++;
                sb_q.push_back(e);
                done = 1;
            end else begin
                if (watch_ready && !saw_low) begin
                    saw_low = 1;
                    check("held_before_inready_low", sb_q.size(), 2);
                end
                waited++;
                if (waited > 50) begin
                    check("accept_timeout", waited, 0);
                    done = 1;
                end
            end
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        RS       = $urandom;
        RT       = $urandom;
    endtask

    task automatic send_model(input logic [3:0] op, input bit lat);
        logic [31:0] rs, rt, ev;
        logic [4:0]  amt;
        logic        ei;
        rs  = $urandom;
        rt  = $urandom;
        amt = 5'($urandom_range(0, 31));
        model(op, rs, rt, amt, ev, ei);
        send(op, rs, rt, amt, ev, ei, lat);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;
        bit rnd_done;

        vecs[0]  = '{4'd5,  32'h80000001, 32'h00000000, 5'd1,  32'h00000003, 1'b0};
        vecs[1]  = '{4'd6,  32'h00000001, 32'h00000000, 5'd1,  32'h80000000, 1'b0};
        vecs[2]  = '{4'd7,  32'hF0000000, 32'h00000001, 5'd4,  32'h00000010, 1'b0};
        vecs[3]  = '{4'd8,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{4'd8,  32'h00000005, 32'h00000003, 5'd1,  32'h00000001, 1'b0};
        vecs[5]  = '{4'd0,  32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1};
`ifdef SI_ALU_PIPE_EXT_OPS_EN
        vecs[6]  = '{4'd9,  32'h00000001, 32'h00000001, 5'd4,  32'h00000020, 1'b0};
        vecs[7]  = '{4'd10, 32'h00000100, 32'h00000003, 5'd4,  32'h0000000D, 1'b0};
`else
        vecs[6]  = '{4'd9,  32'h00000001, 32'h00000001, 5'd4,  32'h00000000, 1'b1};
        vecs[7]  = '{4'd10, 32'h00000100, 32'h00000003, 5'd4,  32'h00000000, 1'b1};
`endif
        vecs[8]  = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000, 1'b1};
        vecs[9]  = '{4'd5,  32'h0000FFFF, 32'h00FF00FF, 5'd8,  32'hFFFF0000, 1'b0};
        vecs[10] = '{4'd6,  32'h12345678, 32'hFFFFFFFF, 5'd31, 32'hDB97530F, 1'b0};
        vecs[11] = '{4'd7,  32'hFFFFFFFF, 32'h00000002, 5'd5,  32'h00000001, 1'b0};
        vecs[12] = '{4'd8,  32'h00000010, 32'h00000001, 5'd4,  32'hF0000000, 1'b0};
        vecs[13] = '{4'd6,  32'hA5A5A5A5, 32'h00000000, 5'd0,  32'hA5A5A5A5, 1'b0};

        // Reset state while RST_N is held low.
        repeat (2) @(posedge CLK);
        #1;
        check("reset_out_valid", OUT_VALID, 1'b0);
        check("reset_in_ready", IN_READY, 1'b1);
        check("reset_val", VAL, 32'h0);
        check("reset_illegal", ILLEGAL, 1'b0);
        RST_N = 1'b1;

        // Directed vectors, one at a time; the first goes in on the edge right after release.
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].amt, vecs[i].exp_val, vecs[i].exp_ill, 1'b1);
            wait_drain(20);
        end

        // Eight back-to-back ops with the consumer stalled for four cycles.
        out_before  = n_out;
        watch_ready = 1;
        saw_low     = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_model(4'(5 + $urandom_range(0, 3)), 1'b0);
            end
            begin
                repeat (3) @(posedge CLK);
                #1 OUT_READY = 1'b0;
                repeat (4) @(posedge CLK);
                #1 OUT_READY = 1'b1;
            end
        join
        wait_drain(30);
        watch_ready = 0;
        check("inready_dropped", saw_low, 1'b1);
        check("stall_burst_count", n_out - out_before, 8);

        // Random opcodes with a randomly toggling consumer.
        out_before = n_out;
        rnd_done   = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) send_model(4'($urandom_range(0, 15)), 1'b0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK); #1;
                    OUT_READY = 1'($urandom_range(0, 1));
                end
                OUT_READY = 1'b1;
            end
        join
        wait_drain(60);
        check("random_burst_count", n_out - out_before, 24);

        // Reset with two operations in flight.
        out_before = n_out;
        send_model(4'd7, 1'b0);
        send_model(4'd8, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("midreset_out_valid", OUT_VALID, 1'b0);
        check("midreset_in_ready", IN_READY, 1'b1);
        check("midreset_val", VAL, 32'h0);
        check("midreset_illegal", ILLEGAL, 1'b0);
        sb_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check("midreset_no_emit", n_out - out_before, 0);
        send(4'd5, 32'h80000001, 32'h00000000, 5'd1, 32'h00000003, 1'b0, 1'b1);
        wait_drain(20);
        repeat (3) @(posedge CLK);
        #1;
        check("post_reset_count", n_out - out_before, 1);
        check("final_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/si_alu_pipe.md
SI_ALU_PIPE -- requirements
Module: si_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, >= 8).
REQ-002 SHALL have parameter ROT_W, default $clog2(WIDTH), rotate-amount width (derived; not overridden).
REQ-003 SHALL have port CLK  input  1  single clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  operand set valid.
REQ-006 SHALL have port IN_READY  output  1  block accepts operand set.
REQ-007 SHALL have port RS  input  WIDTH  first operand.
REQ-008 SHALL have port RT  input  WIDTH  second operand.
REQ-009 SHALL have port ROT_AM  input  ROT_W  rotate amount.
REQ-010 SHALL have port ALU_CNTRL  input  4  opcode.
REQ-011 SHALL have port OUT_VALID  output  1  result valid.
REQ-012 SHALL have port OUT_READY  input  1  consumer accepts result.
REQ-013 SHALL have port VAL  output  WIDTH  result.
REQ-014 SHALL have port ILLEGAL  output  1  result came from an unsupported opcode.

Function
REQ-015 SHALL transfer input when IN_VALID && IN_READY at a CLK edge; output when OUT_VALID && OUT_READY.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers first sub-operation, stage 2 registers final result; latency exactly 2 cycles from accept to OUT_VALID with no stall.
REQ-017 SHALL sustain one accepted operand set per cycle while OUT_READY stays high.
REQ-018 SHALL compute true rotates (bits wrap), amount taken modulo WIDTH; ROT_AM=0 means no rotation.
REQ-019 SHALL implement opcode 5: rotl(RS ^ RT, ROT_AM).
REQ-020 SHALL implement opcode 6: rotr(RS, ROT_AM) ^ RT.
REQ-021 SHALL implement opcode 7: rotl(RS, ROT_AM) + RT, modulo 2^WIDTH, carry discarded.
REQ-022 SHALL implement opcode 8: rotr(RS - RT, ROT_AM), modulo 2^WIDTH, borrow discarded.
REQ-023 SHALL, for any other opcode (subject to REQ-034), produce VAL=0 and ILLEGAL=1; ILLEGAL=0 for supported opcodes.
REQ-024 SHALL stall: stage 2 holds when OUT_VALID && !OUT_READY; stage 1 advances only if stage 2 empty or draining; IN_READY = !s1_valid || s1_advance (combinational, no dependence on IN_VALID).
REQ-025 SHALL keep VAL/ILLEGAL stable while OUT_VALID && !OUT_READY.
REQ-026 SHALL, on simultaneous output-drain and input-accept with a full pipeline, shift both stages in the same cycle without bubble or loss.
REQ-027 SHALL ignore RS/RT/ROT_AM/ALU_CNTRL when IN_VALID is low or IN_READY is low.

Reset
REQ-028 SHALL, while RST_N low, force OUT_VALID=0, VAL=0, ILLEGAL=0, both stage-valid flags 0, IN_READY=1.
REQ-029 SHALL discard all in-flight operations on reset assertion mid-operation; no result emitted afterwards.
REQ-030 SHALL accept input on the first CLK edge after RST_N deasserts.

Configuration
REQ-031 SHALL recognise macro SI_ALU_PIPE_EXT_OPS_EN.
REQ-032 SHALL, with macro defined, implement opcode 9: rotl(RS + RT, ROT_AM).
REQ-033 SHALL, with macro defined, implement opcode 10: rotr(RS, ROT_AM) - RT.
REQ-034 SHALL, without macro, treat opcodes 9 and 10 as illegal per REQ-023.

Structure
REQ-035 SHALL place opcode localparams (OP_XOR_ROTL=5, OP_ROTR_XOR=6, OP_ROTL_ADD=7, OP_SUB_ROTR=8, OP_ADD_ROTL=9, OP_ROTR_SUB=10) in shared package si_alu_pkg.
REQ-036 SHALL use one combinational sub-module si_rot (WIDTH param, data, amount, direction -> rotated data), instantiated for stage-1 and stage-2 rotates.

Verification (WIDTH=32)
REQ-037 SHALL cover op5 RS=0x80000001 RT=0 ROT_AM=1 -> VAL=0x00000003, ILLEGAL=0, OUT_VALID 2 cycles after accept.
REQ-038 SHALL cover op6 RS=0x00000001 RT=0 ROT_AM=1 -> 0x80000000; op7 RS=0xF0000000 RT=1 ROT_AM=4 -> 0x00000010.
REQ-039 SHALL cover op8 RS=0 RT=1 ROT_AM=0 -> 0xFFFFFFFF; op8 RS=5 RT=3 ROT_AM=1 -> 0x00000001.
REQ-040 SHALL cover opcode 0 (and 9 without macro) -> VAL=0, ILLEGAL=1.
REQ-041 SHALL cover 8 back-to-back ops with OUT_READY low for cycles 3-6 -> IN_READY drops after 2 held results, all 8 results in order, none lost or duplicated, VAL stable while stalled.
REQ-042 SHALL cover RST_N pulsed low with 2 ops in flight -> OUT_VALID=0 immediately, no result emitted, next op after release yields correct value at latency 2.
